// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: writeback arbiter and sole driver of the register-file
// write port (load/dest/in).
//   Sources  : in-order pipeline commits (pipe_*, cannot stall) and a
//              long-latency unit (ll_*, valid/ready) buffered in a DEPTH FIFO.
//   Priority : pipe_valid always wins. The FIFO head drains only when
//              pipe_valid=0.
//   Hazards  : pending_mask flags every destination that is queued or sitting
//              in the output register.
//   Fairness : stall_req pulses for one cycle after the head has waited
//              STARVE_LIMIT cycles. The pipeline must then idle, so the head
//              drains.
//   x0       : writes to x0 are swallowed. A pipe commit to x0 gives load=0,
//              and a long-latency result to x0 is handshaken but never queued.
// Ports: clk, rst_n (async active-low); pipe_valid/pipe_rd/pipe_data;
//        ll_valid/ll_ready/ll_rd/ll_data; stall_req; pending_mask[31:0];
//        load/dest[4:0]/in[31:0] (registered regfile write port).
// Optional macro WB_BYPASS_EN: when the FIFO is empty and the pipe is idle,
//        an accepted long-latency result goes straight to the output register.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_data,
    output logic        stall_req,
    output logic [31:0] pending_mask,
    output logic        load,
    output logic [4:0]  dest,
    output logic [31:0] in
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT);

    logic [4:0]    rd_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          load_q, load_d;
    logic [4:0]    dest_q, dest_d;
    logic [31:0]   in_q, in_d;

    logic          fifo_empty, accept, drain, bypass, push, waiting;
    logic [PW-1:0] off;
    logic [31:0]   mask;

    always_comb begin
        fifo_empty = (count_q == '0);
        ll_ready   = (count_q < (PW+1)'(DEPTH));
        accept     = ll_valid && ll_ready;
        drain      = !pipe_valid && !fifo_empty;
`ifdef WB_BYPASS_EN
        bypass     = accept && (ll_rd != 5'd0) && fifo_empty && !pipe_valid;
`else
        bypass     = 1'b0;
`endif
        // An x0 result completes its handshake but is dropped here.
        push       = accept && (ll_rd != 5'd0) && !bypass;
        waiting    = !fifo_empty && !drain;
    end

    // The output register takes the pipe first, then the FIFO head, then the
    // bypass path. dest/in hold their value on idle cycles.
    always_comb begin
        load_d = 1'b0;
        dest_d = dest_q;
        in_d   = in_q;
        if (pipe_valid) begin
            load_d = (pipe_rd != 5'd0);
            dest_d = pipe_rd;
            in_d   = pipe_data;
        end else if (drain) begin
            load_d = 1'b1;
            dest_d = rd_mem_q[rd_ptr_q];
            in_d   = data_mem_q[rd_ptr_q];
        end else if (bypass) begin
            load_d = 1'b1;
            dest_d = ll_rd;
            in_d   = ll_data;
        end
    end

    always_comb begin
        wr_ptr_d = push  ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = drain ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !drain)
            count_d = count_q + (PW+1)'(1);
        else if (!push && drain)
            count_d = count_q - (PW+1)'(1);
    end

    // The counter saturates at STARVE_LIMIT-1. stall_req therefore keeps
    // firing until the head actually drains, and never fires in a drain cycle.
    always_comb begin
        starve_d = '0;
        if (waiting)
            starve_d = (starve_q == CW'(STARVE_LIMIT-1)) ? starve_q : starve_q + CW'(1);
        stall_d = waiting && (starve_q == CW'(STARVE_LIMIT-1));
    end

    // Slot i is live when its distance from the head (mod DEPTH) is below count.
    always_comb begin
        mask = '0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q)
                mask = mask | (32'd1 << rd_mem_q[i]);
        end
        if (load_q)
            mask = mask | (32'd1 << dest_q);
        mask[0] = 1'b0;
        pending_mask = mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            load_q   <= 1'b0;
            dest_q   <= '0;
            in_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            load_q   <= load_d;
            dest_q   <= dest_d;
            in_q     <= in_d;
        end
    end

    // The storage needs no reset. Validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= ll_rd;
            data_mem_q[wr_ptr_q] <= ll_data;
        end
    end

    assign stall_req = stall_q;
    assign load      = load_q;
    assign dest      = dest_q;
    assign in        = in_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        stall_req;
    logic [31:0] pending_mask;
    logic        load;
    logic [4:0]  dest;
    logic [31:0] in;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
        .stall_req(stall_req), .pending_mask(pending_mask),
        .load(load), .dest(dest), .in(in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // The pipeline must be idle in any cycle where stall_req is high.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && stall_req === 1'b1) begin
            n_assert++;
            assert (pipe_valid === 1'b0) else begin
                n_fail++;
                $error("FAIL stall_honoured: observed pipe_valid=%0b expected 0", pipe_valid);
            end
        end
    end

    initial begin
        rst_n = 1'b0; pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
        #12;
        chk("rst_load",  32'(load), 32'd0);
        chk("rst_dest",  32'(dest), 32'd0);
        chk("rst_in",    in, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_ready", 32'(ll_ready), 32'd1);
        chk("rst_mask",  pending_mask, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single pipe commit
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        tick();
        pipe_valid = 1'b0;
        chk("pipe_load", 32'(load), 32'd1);
        chk("pipe_dest", 32'(dest), 32'd5);
        chk("pipe_in",   in, 32'hDEADBEEF);
        chk("pipe_mask", pending_mask, 32'h20);
        tick();
        chk("pipe_load_drop", 32'(load), 32'd0);

        // Long-latency result with the pipe idle
        ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h1234;
        tick();
        ll_valid = 1'b0;
`ifdef WB_BYPASS_EN
        chk("ll_byp_load", 32'(load), 32'd1);
        chk("ll_byp_dest", 32'(dest), 32'd7);
        chk("ll_byp_mask", pending_mask, 32'h80);
`else
        chk("ll_q_load",  32'(load), 32'd0);
        chk("ll_q_mask",  pending_mask, 32'h80);
        tick();
        chk("ll_load",    32'(load), 32'd1);
        chk("ll_dest",    32'(dest), 32'd7);
        chk("ll_in",      in, 32'h1234);
        chk("ll_out_mask", pending_mask, 32'h80);
`endif
        tick();
        chk("ll_load_drop", 32'(load), 32'd0);
        chk("ll_mask_clr",  pending_mask, 32'd0);

        // Fill the FIFO while the pipe commits to x0 every cycle
        for (int k = 1; k <= 4; k++) begin
            pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'(k);
            ll_valid = 1'b1; ll_rd = 5'(k); ll_data = 32'h100 + 32'(k);
            tick();
            chk("fill_ready", 32'(ll_ready), (k < 4) ? 32'd1 : 32'd0);
            chk("fill_load",  32'(load), 32'd0);
        end
        ll_valid = 1'b0;
        chk("full_mask", pending_mask, 32'h1E);
        for (int t = 5; t <= 8; t++) begin
            tick();
            chk("starve_wait1", 32'(stall_req), 32'd0);
        end
        tick();
        chk("starve_pulse1", 32'(stall_req), 32'd1);
        pipe_valid = 1'b0;
        tick();
        chk("drain1_load",  32'(load), 32'd1);
        chk("drain1_dest",  32'(dest), 32'd1);
        chk("drain1_in",    in, 32'h101);
        chk("drain1_stall", 32'(stall_req), 32'd0);
        chk("drain1_mask",  pending_mask, 32'h1E);
        chk("drain1_ready", 32'(ll_ready), 32'd1);
        pipe_valid = 1'b1; pipe_rd = 5'd0;
        for (int t = 11; t <= 17; t++) begin
            tick();
            chk("starve_wait2", 32'(stall_req), 32'd0);
        end
        tick();
        chk("starve_pulse2", 32'(stall_req), 32'd1);
        pipe_valid = 1'b0;
        tick();
        chk("drain2_dest", 32'(dest), 32'd2);
        chk("drain2_in",   in, 32'h102);
        chk("drain2_stall", 32'(stall_req), 32'd0);
        tick();
        chk("drain3_dest", 32'(dest), 32'd3);
        tick();
        chk("drain4_load", 32'(load), 32'd1);
        chk("drain4_dest", 32'(dest), 32'd4);
        chk("drain4_in",   in, 32'h104);
        chk("drain4_mask", pending_mask, 32'h10);
        tick();
        chk("empty_load", 32'(load), 32'd0);
        chk("empty_mask", pending_mask, 32'd0);

        // Writes to x0 from both sources
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFF;
        ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h55;
        tick();
        pipe_valid = 1'b0; ll_valid = 1'b0;
        chk("x0_load",  32'(load), 32'd0);
        chk("x0_mask",  pending_mask, 32'd0);
        chk("x0_ready", 32'(ll_ready), 32'd1);
        tick();
        chk("x0_nodrain", 32'(load), 32'd0);

        // Reset with three queued entries
        for (int k = 0; k < 3; k++) begin
            pipe_valid = 1'b1; pipe_rd = 5'd0;
            ll_valid = 1'b1; ll_rd = (k == 0) ? 5'd3 : (k == 1) ? 5'd5 : 5'd6;
            ll_data = 32'hA0 + 32'(k);
            tick();
        end
        ll_valid = 1'b0;
        chk("q3_mask", pending_mask, 32'h68);
        #2 rst_n = 1'b0;
        pipe_valid = 1'b0;
        #1;
        chk("mrst_load",  32'(load), 32'd0);
        chk("mrst_mask",  pending_mask, 32'd0);
        chk("mrst_ready", 32'(ll_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_load", 32'(load), 32'd0);
        chk("post_rst_mask", pending_mask, 32'd0);
        tick();
        chk("post_rst_load2", 32'(load), 32'd0);
        chk("post_rst_ready", 32'(ll_ready), 32'd1);

        pipe_valid = 1'b1; pipe_rd = 5'd31; pipe_data = 32'hCAFEF00D;
        tick();
        pipe_valid = 1'b0;
        chk("post_rst_wr_dest", 32'(dest), 32'd31);
        chk("post_rst_wr_in",   in, 32'hCAFEF00D);
        chk("post_rst_wr_mask", pending_mask, 32'h80000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
